ctrl_pipe_unit: RTL
===================

# ctrl_pipe_unit

Pipelined main control unit for the 5-stage MIPS core. It decodes the ID-stage instruction into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers, so each stage reads its own controls. It also detects load-use and branch-operand hazards, resolves BEQ/BNE/J/JAL in ID, and drives the PC-select, stall and IF/ID-flush signals. Register-address width, function width and link register are parameters.

## Interface
- RA_W, 5, register-address width
- FUNC_W, 6, ALU function-code width
- LINK_REG, 31, JAL destination register index
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- opcode  in  6  ID instruction opcode
- func_in  in  FUNC_W  ID instruction funct field
- rs, rt, rd  in  RA_W  ID register fields
- eq_regs  in  1  ID comparator: rs value == rt value
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target (combinational)
- stall  out  1  hold PC and IF/ID; bubble into EX (combinational)
- flush_if_id  out  1  zero IF/ID next edge (combinational)
- illegal  out  1  ID opcode not decoded (combinational)
- ex_alu_src, ex_reg_dst_sel  out  1  EX controls
- ex_func  out  FUNC_W  EX ALU function
- ex_dst  out  RA_W  EX resolved write register
- mem_read, mem_write  out  1  MEM controls
- wb_reg_write, wb_mem_to_reg, wb_link  out  1  WB controls
- wb_dst  out  RA_W  WB write register

## Operation
- Decode (ID), destination resolved in ID:
  - RTYPE 000000: reg_write=1, dst=rd, func=func_in. An all-zero instruction is a NOP, forced to reg_write=0.
  - LW 100011: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, dst=rt, func=ADD (100000).
  - SW 101011: alu_src=1, mem_write=1, func=ADD.
  - ADDI 001000: alu_src=1, reg_write=1, dst=rt, func=ADD.
  - BEQ 000100 and BNE 000101: no EX/MEM/WB effects.
  - J 000010: no EX/MEM/WB effects.
  - JAL 000011: reg_write=1, link=1, dst=LINK_REG.
  - Any other opcode: all controls 0; illegal=1.
- Writes with dst==0 are forced to reg_write=0.
- Uses-rt: RTYPE, SW, BEQ, BNE. Uses-rs: all opcodes except J and JAL.
- Load-use stall, non-branch ID instruction: EX.mem_read and EX.dst≠0 and EX.dst matches a used source.
- Branch-operand stall, BEQ/BNE only, either condition:
  - EX.reg_write and EX.dst≠0 and EX.dst matches rs or rt;
  - MEM.mem_read and MEM.dst≠0 and MEM.dst matches rs or rt.
- While stall=1:
  - pc_src=00, flush_if_id=0;
  - ID/EX loads a bubble (all controls 0);
  - EX/MEM and MEM/WB advance normally.
- Branch resolution when not stalled:
  - BEQ with eq_regs=1 → pc_src=01, flush=1.
  - BNE with eq_regs=0 → pc_src=01, flush=1.
  - Otherwise pc_src=00.
- J and JAL: pc_src=10, flush=1. These never stall.
- The flushed IF/ID slot reaches ID as opcode 000000 with func 000000, i.e. a NOP.

## Timing
- ID outputs (pc_src, stall, flush_if_id, illegal) are combinational from the current inputs and pipeline registers.
- Latency, from the edge that captures ID controls:
  - EX controls are valid 1 cycle later.
  - MEM controls are valid 2 cycles later.
  - WB controls are valid 3 cycles later.
- Every pipeline register is clocked every edge; there is no enable.
- Reset:
  - rst=1 at an edge clears all stage registers to a bubble.
  - Every registered output reads 0 from the next cycle.
  - While rst=1, the combinational outputs are forced to pc_src=00, stall=0, flush=0, illegal=0.
  - This holds even mid-stall or mid-branch; the pending stall is discarded.
- Stall durations:
  - Load-use stall: exactly 1 cycle.
  - Branch after an ALU producer in EX: 1 cycle.
  - Branch directly after LW: 2 cycles (EX match, then MEM match).
- Simultaneous events: a stall takes priority over branch resolution; no pc_src≠00 while stall=1.

## Test plan
- Reset: drive random inputs with rst=1 for 2 cycles → all registered outputs 0; pc_src=00, stall=0.
- LW r2 then ADD r3,r2,r4 → stall=1 for exactly 1 cycle; EX shows a bubble; ADD reaches EX one cycle later with ex_dst=3, ex_func=100000.
- LW r5, then BEQ r5,r0 with eq_regs=1 → stall high for 2 cycles; then pc_src=01 and flush=1 for 1 cycle.
- BNE with eq_regs=1 → pc_src=00. BNE with eq_regs=0 → pc_src=01, flush=1.
- JAL → pc_src=10, flush=1; 3 cycles later wb_link=1, wb_reg_write=1, wb_dst=31.
- ADDI with rt=0, and opcode 111111 → no writes reach WB; illegal=1 only for 111111.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// Pipelined main control for the 5-stage MIPS core: ID decode, hazard
// detection, ID-stage branch/jump resolution and the ID/EX, EX/MEM, MEM/WB control registers.
module ctrl_pipe_unit #(
  parameter int RA_W     = 5,
  parameter int FUNC_W   = 6,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [FUNC_W-1:0] func_in,
  input  logic [RA_W-1:0]   rs,
  input  logic [RA_W-1:0]   rt,
  input  logic [RA_W-1:0]   rd,
  input  logic              eq_regs,
  output logic [1:0]        pc_src,
  output logic              stall,
  output logic              flush_if_id,
  output logic              illegal,
  output logic              ex_alu_src,
  output logic              ex_reg_dst_sel,
  output logic [FUNC_W-1:0] ex_func,
  output logic [RA_W-1:0]   ex_dst,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              wb_link,
  output logic [RA_W-1:0]   wb_dst
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [FUNC_W-1:0] FUNC_ADD = FUNC_W'(32);
  localparam logic [RA_W-1:0]   DST_LINK = RA_W'(LINK_REG);

  logic              w_alu_src, w_reg_dst_sel, w_mem_read, w_mem_write;
  logic              w_reg_write, w_mem_to_reg, w_link, w_legal;
  logic              w_uses_rs, w_uses_rt, w_is_br, w_is_jmp, w_wr;
  logic [FUNC_W-1:0] w_func;
  logic [RA_W-1:0]   w_dst;
  logic              w_load_use, w_br_stall, w_taken, w_stall;

  logic              r_ex_alu_src, r_ex_reg_dst_sel, r_ex_mem_read, r_ex_mem_write;
  logic              r_ex_reg_write, r_ex_mem_to_reg, r_ex_link;
  logic [FUNC_W-1:0] r_ex_func;
  logic [RA_W-1:0]   r_ex_dst;
  logic              r_mem_mem_read, r_mem_mem_write, r_mem_reg_write;
  logic              r_mem_mem_to_reg, r_mem_link;
  logic [RA_W-1:0]   r_mem_dst;
  logic              r_wb_reg_write, r_wb_mem_to_reg, r_wb_link;
  logic [RA_W-1:0]   r_wb_dst;

  always_comb begin
    w_alu_src     = 1'b0;
    w_reg_dst_sel = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_link        = 1'b0;
    w_legal       = 1'b1;
    w_uses_rs     = 1'b1;
    w_uses_rt     = 1'b0;
    w_is_br       = 1'b0;
    w_is_jmp      = 1'b0;
    w_func        = '0;
    w_dst         = '0;
    case (opcode)
      OP_RTYPE: begin
        // All-zero instruction (incl. flushed slot) is a NOP.
        w_reg_write   = (rs != '0) || (rt != '0) || (rd != '0) || (func_in != '0);
        w_reg_dst_sel = 1'b1;
        w_dst         = rd;
        w_func        = func_in;
        w_uses_rt     = 1'b1;
      end
      OP_LW: begin
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_dst        = rt;
        w_func       = FUNC_ADD;
      end
      OP_SW: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_func      = FUNC_ADD;
        w_uses_rt   = 1'b1;
      end
      OP_ADDI: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_dst       = rt;
        w_func      = FUNC_ADD;
      end
      OP_BEQ, OP_BNE: begin
        w_is_br   = 1'b1;
        w_uses_rt = 1'b1;
      end
      OP_J: begin
        w_is_jmp  = 1'b1;
        w_uses_rs = 1'b0;
      end
      OP_JAL: begin
        w_is_jmp    = 1'b1;
        w_uses_rs   = 1'b0;
        w_reg_write = 1'b1;
        w_link      = 1'b1;
        w_dst       = DST_LINK;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_wr = w_reg_write && (w_dst != '0);

  assign w_load_use = !w_is_br && r_ex_mem_read && (r_ex_dst != '0) &&
                      ((w_uses_rs && (rs == r_ex_dst)) || (w_uses_rt && (rt == r_ex_dst)));

  // Branches compare in ID, so they must wait for any in-flight producer.
  assign w_br_stall = w_is_br &&
                      ((r_ex_reg_write && (r_ex_dst != '0) &&
                        ((rs == r_ex_dst) || (rt == r_ex_dst))) ||
                       (r_mem_mem_read && (r_mem_dst != '0) &&
                        ((rs == r_mem_dst) || (rt == r_mem_dst))));

  assign w_taken = ((opcode == OP_BEQ) && eq_regs) || ((opcode == OP_BNE) && !eq_regs);
  assign w_stall = !rst && (w_load_use || w_br_stall);

  always_comb begin
    pc_src      = 2'b00;
    flush_if_id = 1'b0;
    if (!rst && !w_stall) begin
      if (w_is_jmp) begin
        pc_src      = 2'b10;
        flush_if_id = 1'b1;
      end else if (w_taken) begin
        pc_src      = 2'b01;
        flush_if_id = 1'b1;
      end
    end
  end

  assign stall   = w_stall;
  assign illegal = !rst && !w_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_alu_src     <= 1'b0;
      r_ex_reg_dst_sel <= 1'b0;
      r_ex_mem_read    <= 1'b0;
      r_ex_mem_write   <= 1'b0;
      r_ex_reg_write   <= 1'b0;
      r_ex_mem_to_reg  <= 1'b0;
      r_ex_link        <= 1'b0;
      r_ex_func        <= '0;
      r_ex_dst         <= '0;
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_to_reg <= 1'b0;
      r_mem_link       <= 1'b0;
      r_mem_dst        <= '0;
      r_wb_reg_write   <= 1'b0;
      r_wb_mem_to_reg  <= 1'b0;
      r_wb_link        <= 1'b0;
      r_wb_dst         <= '0;
    end else begin
      if (w_stall) begin
        r_ex_alu_src     <= 1'b0;
        r_ex_reg_dst_sel <= 1'b0;
        r_ex_mem_read    <= 1'b0;
        r_ex_mem_write   <= 1'b0;
        r_ex_reg_write   <= 1'b0;
        r_ex_mem_to_reg  <= 1'b0;
        r_ex_link        <= 1'b0;
        r_ex_func        <= '0;
        r_ex_dst         <= '0;
      end else begin
        r_ex_alu_src     <= w_alu_src;
        r_ex_reg_dst_sel <= w_reg_dst_sel;
        r_ex_mem_read    <= w_mem_read;
        r_ex_mem_write   <= w_mem_write;
        r_ex_reg_write   <= w_wr;
        r_ex_mem_to_reg  <= w_mem_to_reg;
        r_ex_link        <= w_link;
        r_ex_func        <= w_func;
        r_ex_dst         <= w_dst;
      end
      r_mem_mem_read   <= r_ex_mem_read;
      r_mem_mem_write  <= r_ex_mem_write;
      r_mem_reg_write  <= r_ex_reg_write;
      r_mem_mem_to_reg <= r_ex_mem_to_reg;
      r_mem_link       <= r_ex_link;
      r_mem_dst        <= r_ex_dst;
      r_wb_reg_write   <= r_mem_reg_write;
      r_wb_mem_to_reg  <= r_mem_mem_to_reg;
      r_wb_link        <= r_mem_link;
      r_wb_dst         <= r_mem_dst;
    end
  end

  assign ex_alu_src     = r_ex_alu_src;
  assign ex_reg_dst_sel = r_ex_reg_dst_sel;
  assign ex_func        = r_ex_func;
  assign ex_dst         = r_ex_dst;
  assign mem_read       = r_mem_mem_read;
  assign mem_write      = r_mem_mem_write;
  assign wb_reg_write   = r_wb_reg_write;
  assign wb_mem_to_reg  = r_wb_mem_to_reg;
  assign wb_link        = r_wb_link;
  assign wb_dst         = r_wb_dst;

endmodule
